// File: rtl/ascii_pkg.sv
// ascii_pkg: key-code constants, output FSM states and the key-code to ASCII mapping
package ascii_pkg;

    localparam logic [4:0] CODE_DIGIT_BASE  = 5'd1;
    localparam logic [4:0] CODE_LOWER_BASE  = 5'd10;
    localparam logic [4:0] CODE_UPPER_BASE  = 5'd26;
    localparam logic [4:0] CODE_ENTER       = 5'd16;
    localparam logic [4:0] CODE_PLUS        = 5'd17;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_PLUS       = 8'h2B;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h31;
    localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;
    localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;

    typedef enum logic [1:0] {IDLE, DATA, LF} out_state_t;

    // Returns {hit, ascii}; hit=0 marks an unmapped code.
    function automatic logic [8:0] map_code(input logic [4:0] code, input int group_len);
        logic [8:0] r;
        r = '0;
        if (code >= CODE_DIGIT_BASE && int'(code) < int'(CODE_DIGIT_BASE) + group_len)
            r = {1'b1, ASCII_DIGIT_BASE + 8'(code - CODE_DIGIT_BASE)};
        else if (code >= CODE_LOWER_BASE && int'(code) < int'(CODE_LOWER_BASE) + group_len)
            r = {1'b1, ASCII_LOWER_BASE + 8'(code - CODE_LOWER_BASE)};
        else if (code >= CODE_UPPER_BASE && int'(code) < int'(CODE_UPPER_BASE) + group_len)
            r = {1'b1, ASCII_UPPER_BASE + 8'(code - CODE_UPPER_BASE)};
        else if (code == CODE_ENTER)
            r = {1'b1, ASCII_CR};
        else if (code == CODE_PLUS)
            r = {1'b1, ASCII_PLUS};
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign rdata = mem[rptr];
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: rtl/ascii_tx_queue.sv
// ascii_tx_queue: maps key codes to ASCII, queues them and streams them out with optional LF after CR
module ascii_tx_queue
    import ascii_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int GROUP_LEN   = 5,
    parameter int LF_AFTER_CR = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 key_code,
    input  logic                       key_valid,
    input  logic                       clr_flags,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       code_err,
    output logic                       overflow
);
    out_state_t state;
    logic [8:0] mapped;
    logic [7:0] head;
    logic       full, empty, push, pop, hs, to_lf, hit;

    assign mapped = map_code(key_code, GROUP_LEN);
    assign hit    = mapped[8];
    assign hs     = tx_valid & tx_ready;
    assign to_lf  = state == DATA && hs && tx_data == ASCII_CR && LF_AFTER_CR != 0;
    assign pop    = !empty && (state == IDLE || (hs && !to_lf));
    assign push   = key_valid && hit && (!full || pop);

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (mapped[7:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Error pulse for unmapped codes; sticky overflow where a new drop beats clr_flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            code_err <= key_valid && !hit;
            overflow <= (key_valid && hit && full && !pop) ? 1'b1 : clr_flags ? 1'b0 : overflow;
        end
    end

    // Output slot FSM: inserts LF after a sent CR, otherwise refills from the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (to_lf) begin
            state    <= LF;
            tx_data  <= ASCII_LF;
        end else if (pop) begin
            state    <= DATA;
            tx_data  <= head;
            tx_valid <= 1'b1;
        end else if (hs) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ascii_tx_queue.sv
// tb_ascii_tx_queue: randomized self-checking bench against a byte-stream reference model
module tb_ascii_tx_queue;
    localparam int DEPTH = 16;
    localparam int GL    = 5;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    key_code = '0;
    logic          key_valid = 1'b0;
    logic          clr_flags = 1'b0;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data, b_tx_data;
    logic          tx_valid, b_tx_valid;
    logic [LW-1:0] level, b_level;
    logic          code_err, b_code_err, overflow, b_overflow;

    int total = 0;
    int bad   = 0;
    logic [7:0] got [$];
    logic [7:0] got_b [$];
    logic [7:0] exp [$];
    logic [8:0] ref_map [32];

    always #5 clk = ~clk;

    ascii_tx_queue #(.DEPTH(DEPTH), .GROUP_LEN(GL), .LF_AFTER_CR(1)) u_dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .clr_flags(clr_flags),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .level(level),
        .code_err(code_err), .overflow(overflow)
    );

    ascii_tx_queue #(.DEPTH(DEPTH), .GROUP_LEN(GL), .LF_AFTER_CR(0)) u_nolf (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .clr_flags(clr_flags),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready), .level(b_level),
        .code_err(b_code_err), .overflow(b_overflow)
    );

    task automatic build_map();
        for (int c = 0; c < 32; c++) ref_map[c] = '0;
        for (int k = 0; k < GL; k++) begin
            ref_map[1 + k]  = {1'b1, 8'(8'h31 + k)};
            ref_map[10 + k] = {1'b1, 8'(8'h61 + k)};
            ref_map[26 + k] = {1'b1, 8'(8'h41 + k)};
        end
        ref_map[16] = {1'b1, 8'h0D};
        ref_map[17] = {1'b1, 8'h2B};
    endtask

    function automatic logic [4:0] rand_mapped();
        int k = int'($urandom_range(GL - 1));
        case ($urandom_range(3))
            0:       return 5'(1 + k);
            1:       return 5'(10 + k);
            2:       return 5'(26 + k);
            default: return 5'd17;
        endcase
    endfunction

    task automatic step();
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (b_tx_valid && tx_ready) got_b.push_back(b_tx_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        clr_flags = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        got_b.delete();
        exp.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (code_err !== 1'b0) begin bad++; $display("FAIL reset_code_err got=%b want=0", code_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        do_reset();
    endtask

    task automatic test_order();
        logic [4:0] codes [4];
        codes = '{5'd1, 5'd10, 5'd26, 5'd17};
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL latency_n1 got=%b want=0", tx_valid); end
            end
            if (i == 2) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== ref_map[1][7:0]) begin
                    bad++; $display("FAIL latency_n2 got=%b/%h want=1/%h", tx_valid, tx_data, ref_map[1][7:0]);
                end
            end
            key_code = codes[i];
            key_valid = 1'b1;
            exp.push_back(ref_map[codes[i]][7:0]);
            step();
        end
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        total++; if (got.size() != 4) begin bad++; $display("FAIL order_len got=%0d want=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL order_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_cr();
        do_reset();
        tx_ready = 1'b1;
        key_code = 5'd16;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (got.size() != 2 || got[0] !== 8'h0D || got[1] !== 8'h0A) begin
            bad++; $display("FAIL cr_lf got_n=%0d first=%h want=2 bytes 0d 0a", got.size(), got.size() > 0 ? got[0] : 8'hxx);
        end
        total++;
        if (got_b.size() != 1 || got_b[0] !== 8'h0D) begin
            bad++; $display("FAIL cr_only got_n=%0d want=1 byte 0d", got_b.size());
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL cr_idle got=%b want=0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [4:0] c;
        do_reset();
        key_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = rand_mapped();
            key_code = c;
            if (i < DEPTH + 1) exp.push_back(ref_map[c][7:0]);
            step();
        end
        key_valid = 1'b0;
        total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d want=%0d", level, DEPTH); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        key_valid = 1'b1;
        key_code = rand_mapped();
        clr_flags = 1'b1;
        step();
        key_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", overflow); end
        step();
        clr_flags = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 6; i++) step();
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL ovf_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL ovf_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_code_err();
        logic [4:0] bad_codes [2];
        bad_codes = '{5'd7, 5'd31};
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            key_code = bad_codes[i];
            key_valid = 1'b1;
            step();
            key_valid = 1'b0;
            total++; if (code_err !== 1'b1) begin bad++; $display("FAIL err_pulse%0d got=%b want=1", i, code_err); end
            total++; if (level !== '0 || tx_valid !== 1'b0) begin bad++; $display("FAIL err_nopush%0d level=%0d valid=%b want=0/0", i, level, tx_valid); end
            step();
            total++; if (code_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle%0d got=%b want=0", i, code_err); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL err_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [4:0] c;
        do_reset();
        key_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = rand_mapped();
            key_code = c;
            exp.push_back(ref_map[c][7:0]);
            step();
        end
        key_valid = 1'b0;
        total++; if (level !== LW'(DEPTH) || overflow !== 1'b0) begin bad++; $display("FAIL full_pre level=%0d ovf=%b want=%0d/0", level, overflow, DEPTH); end
        c = rand_mapped();
        key_code = c;
        key_valid = 1'b1;
        tx_ready = 1'b1;
        exp.push_back(ref_map[c][7:0]);
        step();
        key_valid = 1'b0;
        tx_ready = 1'b0;
        total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_pop_level got=%0d want=%0d", level, DEPTH); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pop_ovf got=%b want=0", overflow); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 6; i++) step();
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL full_pop_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL full_pop_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key_valid = 1'b1;
        key_code = 5'd16;
        step();
        for (int i = 0; i < 3; i++) begin
            key_code = rand_mapped();
            step();
        end
        key_valid = 1'b0;
        total++; if (level !== LW'(3) || tx_data !== 8'h0D) begin bad++; $display("FAIL mid_pre level=%0d data=%h want=3/0d", level, tx_data); end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        total++;
        if (tx_data !== 8'h0A || tx_valid !== 1'b1 || level !== LW'(3)) begin
            bad++; $display("FAIL mid_lf data=%h valid=%b level=%0d want=0a/1/3", tx_data, tx_valid, level);
        end
        rst = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0 || level !== '0) begin bad++; $display("FAIL mid_async valid=%b level=%0d want=0/0", tx_valid, level); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        total++; if (got.size() != 0) begin bad++; $display("FAIL mid_no_output got=%0d bytes want=0", got.size()); end
    endtask

    task automatic test_random();
        logic prev_err;
        logic [4:0] c;
        do_reset();
        prev_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            total++; if (code_err !== prev_err) begin bad++; $display("FAIL rand_code_err cyc=%0d got=%b want=%b", i, code_err, prev_err); end
            c = 5'($urandom_range(31));
            key_code = c;
            key_valid = $urandom_range(3) == 0;
            tx_ready = $urandom_range(3) != 0;
            prev_err = key_valid && !ref_map[c][8];
            if (key_valid && ref_map[c][8]) begin
                exp.push_back(ref_map[c][7:0]);
                if (ref_map[c][7:0] == 8'h0D) exp.push_back(8'h0A);
            end
            step();
        end
        key_valid = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 60; i++) step();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%b want=0", overflow); end
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        build_map();
        test_reset();
        test_order();
        test_cr();
        test_overflow();
        test_code_err();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
